// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/bypass controller for the F,D,X,M,W pipeline: operand forwarding selects,
// load-use stall, branch flush and multdiv start/freeze. Optional macro: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned DEPTH      = 3,
   parameter int unsigned SEL_W      = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  dec_valid,
   input  logic [REG_ADDR_W-1:0] dec_rs,
   input  logic [REG_ADDR_W-1:0] dec_rt,
   input  logic                  dec_use_a,
   input  logic                  dec_use_b,
   input  logic [REG_ADDR_W-1:0] dec_rd,
   input  logic                  dec_wr_en,
   input  logic                  dec_is_load,
   input  logic                  dec_is_md,
   input  logic                  br_taken,
   input  logic                  md_ready,
   output logic                  stall,
   output logic                  bubble,
   output logic                  flush,
   output logic                  freeze,
   output logic                  md_start,
   output logic [SEL_W-1:0]      fwd_a_sel,
   output logic [SEL_W-1:0]      fwd_b_sel
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]           perf_stall,
   output logic [31:0]           perf_freeze,
   output logic [31:0]           perf_flush
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  is_load;
      logic                  is_md;
   } entry_t;

   entry_t                tbl [DEPTH];
   entry_t                d_entry;
   logic [REG_ADDR_W-1:0] x_rs;
   logic [REG_ADDR_W-1:0] x_rt;
   logic                  x_use_a;
   logic                  x_use_b;
   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic                  load_use;
   logic                  issue;

   // Multdiv FSM state register
   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next state plus the combinational control outputs; freeze overrides everything else
   always_comb begin
      state_nxt = state;
      freeze    = 1'b0;
      md_start  = 1'b0;
      case (state)
         ST_START: begin
            freeze    = 1'b1;
            md_start  = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT:  freeze = ~md_ready;
         default:  ;
      endcase

      flush    = br_taken & ~freeze;
      load_use = dec_valid & tbl[0].valid & tbl[0].is_load &
                 ((dec_use_a & (tbl[0].rd == dec_rs)) |
                  (dec_use_b & (tbl[0].rd == dec_rt)));
      stall    = load_use & ~flush & ~freeze;
      bubble   = stall;
      issue    = dec_valid & ~stall & ~flush;

      d_entry.valid   = issue & dec_wr_en & (dec_rd != '0);
      d_entry.rd      = dec_rd;
      d_entry.is_load = issue & dec_is_load;
      d_entry.is_md   = issue & dec_is_md;

      // A multdiv entering X starts the unit; otherwise an unfrozen cycle returns to idle
      if (!freeze) state_nxt = d_entry.is_md ? ST_START : ST_IDLE;
   end

   // Forward selects: scan from the oldest so the youngest matching producer wins
   always_comb begin
      fwd_a_sel = '0;
      fwd_b_sel = '0;
      for (int i = int'(DEPTH) - 1; i >= 1; i--) begin
         if (x_use_a && tbl[i].valid && (tbl[i].rd == x_rs)) fwd_a_sel = SEL_W'(i);
         if (x_use_b && tbl[i].valid && (tbl[i].rd == x_rt)) fwd_b_sel = SEL_W'(i);
      end
   end

   // In-flight destination table and X-stage sources, held while frozen
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) tbl[i] <= '0;
         x_rs    <= '0;
         x_rt    <= '0;
         x_use_a <= 1'b0;
         x_use_b <= 1'b0;
      end else if (!freeze) begin
         for (int i = int'(DEPTH) - 1; i >= 1; i--) tbl[i] <= tbl[i-1];
         tbl[0]  <= d_entry;
         x_rs    <= issue ? dec_rs : '0;
         x_rt    <= issue ? dec_rt : '0;
         x_use_a <= issue & dec_use_a;
         x_use_b <= issue & dec_use_b;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Saturating event counters
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_stall  <= '0;
         perf_freeze <= '0;
         perf_flush  <= '0;
      end else begin
         if (stall  && (perf_stall  != 32'hFFFF_FFFF)) perf_stall  <= perf_stall  + 32'd1;
         if (freeze && (perf_freeze != 32'hFFFF_FFFF)) perf_freeze <= perf_freeze + 32'd1;
         if (flush  && (perf_flush  != 32'hFFFF_FFFF)) perf_flush  <= perf_flush  + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed pipeline scenarios, then random traffic,
// every cycle compared against an instruction-level model of the pipeline.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned RW    = 5;
   localparam int unsigned DEPTH = 3;
   localparam int unsigned SW    = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic          dec_valid, dec_use_a, dec_use_b, dec_wr_en, dec_is_load, dec_is_md;
   logic [RW-1:0] dec_rs, dec_rt, dec_rd;
   logic          br_taken, md_ready;
   logic          stall, bubble, flush, freeze, md_start;
   logic [SW-1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0]   perf_stall, perf_freeze, perf_flush;
   logic [31:0]   m_pstall, m_pfreeze, m_pflush;
`endif

   int chk_cnt  = 0;
   int pass_cnt = 0;

   pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .DEPTH(DEPTH), .SEL_W(SW)) dut (
      .clock(clock), .reset(reset),
      .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
      .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_rd(dec_rd),
      .dec_wr_en(dec_wr_en), .dec_is_load(dec_is_load), .dec_is_md(dec_is_md),
      .br_taken(br_taken), .md_ready(md_ready),
      .stall(stall), .bubble(bubble), .flush(flush), .freeze(freeze),
      .md_start(md_start), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall(perf_stall), .perf_freeze(perf_freeze), .perf_flush(perf_flush)
`endif
   );

   always #5 clock = ~clock;

   // Model: destination register of the instruction at each position after D (0 = none),
   // whether it is a load, the registers the X instruction reads (-1 = none) and
   // how far along an outstanding multdiv is (0 none, 1 just entered X, 2 waiting).
   int mdest [DEPTH];
   bit mld   [DEPTH];
   int mxa, mxb;
   int m_md;
   bit e_start, e_freeze, e_flush, e_stall;
   int e_fa, e_fb;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < int'(DEPTH); i++) begin
         mdest[i] = 0;
         mld[i]   = 1'b0;
      end
      mxa  = -1;
      mxb  = -1;
      m_md = 0;
`ifdef HAZARD_PERF_CNT_EN
      m_pstall  = '0;
      m_pfreeze = '0;
      m_pflush  = '0;
`endif
   endfunction

   function automatic void model_outputs();
      bit reads_load;
      e_start  = (m_md == 1);
      e_freeze = (m_md == 1) || (m_md == 2 && !md_ready);
      e_flush  = br_taken && !e_freeze;
      reads_load = mld[0] && mdest[0] != 0 &&
                   ((dec_use_a && int'(dec_rs) == mdest[0]) ||
                    (dec_use_b && int'(dec_rt) == mdest[0]));
      e_stall  = dec_valid && reads_load && !e_flush && !e_freeze;
      e_fa = 0;
      e_fb = 0;
      for (int i = 1; i < int'(DEPTH); i++) begin
         if (e_fa == 0 && mxa >= 0 && mdest[i] != 0 && mdest[i] == mxa) e_fa = i;
         if (e_fb == 0 && mxb >= 0 && mdest[i] != 0 && mdest[i] == mxb) e_fb = i;
      end
   endfunction

   function automatic void model_advance();
      bit issued;
      model_outputs();
`ifdef HAZARD_PERF_CNT_EN
      if (e_stall  && m_pstall  != 32'hFFFF_FFFF) m_pstall++;
      if (e_freeze && m_pfreeze != 32'hFFFF_FFFF) m_pfreeze++;
      if (e_flush  && m_pflush  != 32'hFFFF_FFFF) m_pflush++;
`endif
      if (e_freeze) begin
         if (m_md == 1) m_md = 2;
      end else begin
         issued = dec_valid && !e_stall && !e_flush;
         for (int i = int'(DEPTH) - 1; i >= 1; i--) begin
            mdest[i] = mdest[i-1];
            mld[i]   = mld[i-1];
         end
         mdest[0] = (issued && dec_wr_en) ? int'(dec_rd) : 0;
         mld[0]   = issued && dec_is_load;
         mxa      = (issued && dec_use_a) ? int'(dec_rs) : -1;
         mxb      = (issued && dec_use_b) ? int'(dec_rt) : -1;
         m_md     = (issued && dec_is_md) ? 1 : 0;
      end
   endfunction

   // Called at a negedge with inputs applied: settle and compare outputs against the model
   task automatic step();
      #1;
      if (!reset) begin
         model_outputs();
         check("stall",    32'(stall),     32'(e_stall));
         check("bubble",   32'(bubble),    32'(e_stall));
         check("flush",    32'(flush),     32'(e_flush));
         check("freeze",   32'(freeze),    32'(e_freeze));
         check("md_start", 32'(md_start),  32'(e_start));
         check("fwd_a",    32'(fwd_a_sel), 32'(e_fa));
         check("fwd_b",    32'(fwd_b_sel), 32'(e_fb));
`ifdef HAZARD_PERF_CNT_EN
         check("perf_stall",  perf_stall,  m_pstall);
         check("perf_freeze", perf_freeze, m_pfreeze);
         check("perf_flush",  perf_flush,  m_pflush);
`endif
      end
   endtask

   // Commit the clock edge in the model and move to the next negedge
   task automatic tick();
      if (reset) model_reset();
      else       model_advance();
      @(negedge clock);
   endtask

   task automatic cyc();
      step();
      tick();
   endtask

   task automatic set_dec(input bit v, input int rs, input int rt, input bit ua, input bit ub,
                          input int rd, input bit wr, input bit ld, input bit md);
      dec_valid   = v;
      dec_rs      = RW'(rs);
      dec_rt      = RW'(rt);
      dec_use_a   = ua;
      dec_use_b   = ub;
      dec_rd      = RW'(rd);
      dec_wr_en   = wr;
      dec_is_load = ld;
      dec_is_md   = md;
   endtask

   task automatic idle();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
      br_taken = 1'b0;
      md_ready = 1'b0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      model_reset();
      @(negedge clock);
      cyc();
      cyc();
      reset = 1'b0;

      // Reset state
      step();
      check("rst_stall",  32'(stall),     32'd0);
      check("rst_freeze", 32'(freeze),    32'd0);
      check("rst_fwd_a",  32'(fwd_a_sel), 32'd0);
      tick();

      // 1: back-to-back dependency forwards from M
      set_dec(1, 1, 2, 1, 1, 3, 1, 0, 0); cyc();
      set_dec(1, 3, 3, 1, 1, 4, 1, 0, 0); step(); check("s1_stall", 32'(stall), 32'd0); tick();
      idle(); step();
      check("s1_fwd_a", 32'(fwd_a_sel), 32'd1);
      check("s1_fwd_b", 32'(fwd_b_sel), 32'd1);
      tick();

      // 2: producer two ahead forwards from W
      set_dec(1, 1, 2, 1, 1, 3, 1, 0, 0); cyc();
      idle(); cyc();
      set_dec(1, 3, 1, 1, 1, 5, 1, 0, 0); cyc();
      idle(); step();
      check("s2_fwd_a", 32'(fwd_a_sel), 32'd2);
      check("s2_fwd_b", 32'(fwd_b_sel), 32'd0);
      tick();

      // 3: load-use stall for one cycle, then forward from W
      set_dec(1, 1, 2, 1, 1, 7, 1, 1, 0); cyc();
      set_dec(1, 7, 2, 1, 1, 8, 1, 0, 0); step();
      check("s3_stall", 32'(stall), 32'd1);
      check("s3_bubble", 32'(bubble), 32'd1);
      tick();
      step(); check("s3_stall_rel", 32'(stall), 32'd0); tick();
      idle(); step(); check("s3_fwd_a", 32'(fwd_a_sel), 32'd2); tick();

      // 4: multdiv start pulse, freeze until ready, table held across the freeze
      idle(); cyc(); cyc();
      set_dec(1, 1, 2, 1, 1, 9, 1, 0, 1); cyc();
      set_dec(1, 9, 9, 1, 1, 10, 1, 0, 0); md_ready = 1'b1; step();
      check("s4_start", 32'(md_start), 32'd1);
      check("s4_freeze", 32'(freeze), 32'd1);
      tick();
      md_ready = 1'b0; step();
      check("s4_start_drop", 32'(md_start), 32'd0);
      check("s4_wait_freeze", 32'(freeze), 32'd1);
      tick();
      cyc();
      md_ready = 1'b1; step(); check("s4_release", 32'(freeze), 32'd0); tick();
      idle(); step();
      check("s4_fwd_a", 32'(fwd_a_sel), 32'd1);
      check("s4_fwd_b", 32'(fwd_b_sel), 32'd1);
      tick();

      // 5: branch flush beats load-use stall
      set_dec(1, 1, 2, 1, 1, 7, 1, 1, 0); cyc();
      set_dec(1, 7, 2, 1, 1, 8, 1, 0, 0); br_taken = 1'b1; step();
      check("s5_flush", 32'(flush), 32'd1);
      check("s5_stall", 32'(stall), 32'd0);
      check("s5_bubble", 32'(bubble), 32'd0);
      tick();
      br_taken = 1'b0;
      set_dec(1, 7, 7, 1, 1, 11, 1, 0, 0); step(); check("s5_pos0_inv", 32'(stall), 32'd0); tick();
      idle(); step(); check("s5_fwd_a", 32'(fwd_a_sel), 32'd2); tick();

      // 6: reset while waiting on multdiv
      set_dec(1, 1, 2, 1, 1, 12, 1, 0, 1); cyc();
      idle(); cyc(); cyc();
      reset = 1'b1; cyc();
      reset = 1'b0; step();
      check("s6_freeze", 32'(freeze), 32'd0);
      check("s6_start", 32'(md_start), 32'd0);
      check("s6_stall", 32'(stall), 32'd0);
      check("s6_flush", 32'(flush), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
      check("s6_perf_stall",  perf_stall,  32'd0);
      check("s6_perf_freeze", perf_freeze, 32'd0);
      check("s6_perf_flush",  perf_flush,  32'd0);
`endif
      tick();
      md_ready = 1'b1; step();
      check("s6_ready_ignored", 32'(freeze | md_start), 32'd0);
      tick();

      // Random traffic over a small register set to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         reset       = ($urandom_range(0, 199) == 0);
         dec_valid   = ($urandom_range(0, 4) != 0);
         dec_rs      = RW'($urandom_range(0, 3));
         dec_rt      = RW'($urandom_range(0, 3));
         dec_rd      = RW'($urandom_range(0, 3));
         dec_use_a   = 1'($urandom_range(0, 1));
         dec_use_b   = 1'($urandom_range(0, 1));
         dec_wr_en   = ($urandom_range(0, 3) != 0);
         dec_is_load = ($urandom_range(0, 2) == 0);
         dec_is_md   = ($urandom_range(0, 11) == 0);
         br_taken    = ($urandom_range(0, 9) == 0);
         md_ready    = ($urandom_range(0, 3) == 0);
         cyc();
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
